fp_addsub_seq: RTL and testbench
================================

// Module: fp_addsub_seq
// PURPOSE
//  Multi-cycle FP32 (IEEE-754 single) add/subtract sequencer that wraps the existing 24-bit mantissa
//  adder/subtractor and 8-bit exponent subtractor. Captures one operand pair per valid/ready handshake,
//  aligns and normalises one bit per cycle, then holds the packed result until the consumer accepts it.
//  Sits between the instruction/operand front end and the result writeback.
// PARAMETERS
//  SAT_SHIFT  24  alignment shift cap; larger exponent differences saturate here, which zeroes the mantissa
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   high only in IDLE; transfer when in_valid & in_ready
//  a          in   32  operand A (FP32)
//  b          in   32  operand B (FP32)
//  op         in   1   0 = A+B, 1 = A-B (flips sign of B at capture)
//  out_valid  out  1   result valid, held until out_ready
//  out_ready  in   1   consumer accepts result
//  result     out  32  FP32 result, stable while out_valid
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=32'h0, busy=0, in_ready=1. rst wins over all other inputs and
//  aborts any in-flight operation without emitting a result.
//  FSM: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE; IDLE -> DONE for special operands.
//  - IDLE, on capture: denormal inputs (exp=0) are flushed to +/-0 with hidden bit 0; otherwise hidden bit 1.
//    Swap so exp(X) >= exp(Y); d = exp(X) - exp(Y); cnt = min(d, SAT_SHIFT); k = effective-subtract flag.
//  - Specials (either exp=255): NaN in, or Inf - Inf -> 32'h7FC00000; otherwise Inf with its sign.
//    These go to DONE at t+1.
//  - ALIGN: if cnt==0 go to ADD; else shift Y mantissa right by 1 (truncate) and decrement cnt.
//    Takes cnt+1 cycles.
//  - ADD, 1 cycle: k=0 gives sum; carry-out shifts right by 1 and increments exp. If exp reaches 255,
//    result = +/-Inf and go to DONE. k=1 gives X-Y; a negative result is two's-negated and the sign flipped.
//  - NORM: mant==0 -> result +0, DONE. mant[23]==1 -> pack and go to DONE. Else shift left by 1 and
//    decrement exp. If exp reaches 0 -> +/-0 (flush, no denormal output). Takes n+1 cycles (n = shifts).
//  - DONE: out_valid=1 with result registered. On out_ready go to IDLE; out_valid=0 and in_ready=1 on the
//    next cycle. No same-cycle accept of a new pair.
//  Latency, accept at t to out_valid: cnt + n + 4 for normal operands, 1 for specials. Rounding is
//  truncation toward zero.
//  in_valid while busy is ignored (no capture, no side effect). out_ready outside DONE is ignored.
//  Sign of a normal result is the sign of the larger magnitude; an exact-zero difference gives +0.
// STRUCTURE
//  Shared package fp_addsub_pkg: state enum {IDLE, ALIGN, ADD, NORM, DONE}, FP32_QNAN = 32'h7FC00000,
//  EXP_MAX = 8'hFF, field widths (EXP_W = 8, FRAC_W = 23, MANT_W = 24).
//  One sub-module, fp_unpack (combinational): splits sign/exp/frac, adds hidden bit, flags zero/inf/nan.
//  Instantiated twice.
//  FSM and datapath registers (mantissas, exp, cnt, sign, k) live in fp_addsub_seq.
// TESTING
//  1. a=3F800000 b=3F800000 op=0 -> result 40000000, out_valid at t+4
//  2. a=3FC00000 b=3F800000 op=1 -> result 3F000000 (one NORM shift), out_valid at t+5
//  3. a=3F800000 b=30800000 op=0 (d=30 saturates to 24) -> result 3F800000 at t+28
//  4. a=7F800000 b=FF800000 op=0 -> 7FC00000 at t+1; a=7F7FFFFF b=7F7FFFFF op=0 -> 7F800000
//  5. out_ready held low for 10 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored;
//     then out_ready=1 -> IDLE, next pair processed correctly
//  6. rst asserted during ALIGN of case 3 -> next cycle out_valid=0, in_ready=1, busy=0;
//     then case 1 gives 40000000 at t+4

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the sequential FP32 add/subtract unit.
package fp_addsub_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;

    localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
    localparam logic [31:0]      FP32_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits an FP32 word into sign/exponent/mantissa; denormals are flushed to a zero mantissa.
module fp_unpack
    import fp_addsub_pkg::*;
(
    input  logic [31:0]       fp,
    output logic              sign,
    output logic [EXP_W-1:0]  expo,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic [FRAC_W-1:0] frac;

    assign sign    = fp[31];
    assign expo    = fp[30:23];
    assign frac    = fp[FRAC_W-1:0];
    assign is_zero = (expo == '0);
    assign mant    = is_zero ? '0 : {1'b1, frac};
    assign is_inf  = (expo == EXP_MAX) && (frac == '0);
    assign is_nan  = (expo == EXP_MAX) && (frac != '0);

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP32 add/subtract: one-bit-per-cycle alignment and normalisation, truncating,
// result held under a valid/ready handshake.
module fp_addsub_seq
    import fp_addsub_pkg::*;
#(
    parameter int SAT_SHIFT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int CNT_W = $clog2(SAT_SHIFT + 1);

    function automatic logic [CNT_W-1:0] sat_shift(input logic [EXP_W-1:0] d);
        if (d > EXP_W'(SAT_SHIFT))
            return CNT_W'(SAT_SHIFT);
        return d[CNT_W-1:0];
    endfunction

    function automatic logic [31:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

    function automatic logic [31:0] inf_of(input logic s);
        return {s, EXP_MAX, {FRAC_W{1'b0}}};
    endfunction

    logic              ua_sign, ua_zero, ua_inf, ua_nan;
    logic              ub_sign, ub_zero, ub_inf, ub_nan;
    logic [EXP_W-1:0]  ua_exp, ub_exp;
    logic [MANT_W-1:0] ua_mant, ub_mant;

    fp_unpack u_unpack_a (
        .fp      (a),
        .sign    (ua_sign),
        .expo    (ua_exp),
        .mant    (ua_mant),
        .is_zero (ua_zero),
        .is_inf  (ua_inf),
        .is_nan  (ua_nan)
    );

    fp_unpack u_unpack_b (
        .fp      (b),
        .sign    (ub_sign),
        .expo    (ub_exp),
        .mant    (ub_mant),
        .is_zero (ub_zero),
        .is_inf  (ub_inf),
        .is_nan  (ub_nan)
    );

    state_t            state_q, state_d;
    logic [MANT_W-1:0] mx_q, mx_d, my_q, my_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d, k_q, k_d;
    logic [31:0]       result_q, result_d;

    logic              sb_eff, swap;
    logic [EXP_W-1:0]  d_ab, d_ba, exp_inc, exp_dec;
    logic [MANT_W:0]   sum_w, diff_w, neg_w;

    assign sb_eff  = ub_sign ^ op;
    assign swap    = (ub_exp > ua_exp);
    assign d_ab    = ua_exp - ub_exp;
    assign d_ba    = ub_exp - ua_exp;
    assign exp_inc = exp_q + EXP_W'(1);
    assign exp_dec = exp_q - EXP_W'(1);
    assign sum_w   = {1'b0, mx_q} + {1'b0, my_q};
    assign diff_w  = {1'b0, mx_q} - {1'b0, my_q};
    assign neg_w   = ~diff_w + (MANT_W + 1)'(1);

    always_comb begin
        state_d  = state_q;
        mx_d     = mx_q;
        my_d     = my_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        k_d      = k_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (ua_nan || ub_nan || (ua_inf && ub_inf && (ua_sign != sb_eff))) begin
                        result_d = FP32_QNAN;
                        state_d  = DONE;
                    end else if (ua_inf) begin
                        result_d = inf_of(ua_sign);
                        state_d  = DONE;
                    end else if (ub_inf) begin
                        result_d = inf_of(sb_eff);
                        state_d  = DONE;
                    end else begin
                        // X always carries the larger exponent so only Y ever shifts
                        mx_d    = swap ? ub_mant : ua_mant;
                        my_d    = swap ? ua_mant : ub_mant;
                        exp_d   = swap ? ub_exp  : ua_exp;
                        sign_d  = swap ? sb_eff  : ua_sign;
                        cnt_d   = sat_shift(swap ? d_ba : d_ab);
                        k_d     = (ua_sign ^ sb_eff) & ~ua_zero & ~ub_zero;
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = ADD;
                end else begin
                    my_d  = my_q >> 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADD: begin
                state_d = NORM;
                if (!k_q) begin
                    if (sum_w[MANT_W]) begin
                        mx_d  = sum_w[MANT_W:1];
                        exp_d = exp_inc;
                        if (exp_inc == EXP_MAX) begin
                            result_d = inf_of(sign_q);
                            state_d  = DONE;
                        end
                    end else begin
                        mx_d = sum_w[MANT_W-1:0];
                    end
                end else if (diff_w[MANT_W]) begin
                    mx_d   = neg_w[MANT_W-1:0];
                    sign_d = ~sign_q;
                end else begin
                    mx_d = diff_w[MANT_W-1:0];
                end
            end
            NORM: begin
                if (mx_q == '0) begin
                    result_d = 32'h0;
                    state_d  = DONE;
                end else if (mx_q[MANT_W-1]) begin
                    result_d = pack_fp(sign_q, exp_q, mx_q[FRAC_W-1:0]);
                    state_d  = DONE;
                end else begin
                    mx_d  = mx_q << 1;
                    exp_d = exp_dec;
                    // no denormal outputs: underflow collapses to a signed zero
                    if (exp_dec == '0) begin
                        result_d = {sign_q, 31'h0};
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        mx_q   <= mx_d;
        my_q   <= my_d;
        exp_q  <= exp_d;
        cnt_q  <= cnt_d;
        sign_q <= sign_d;
        k_q    <= k_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed vector table, handshake/reset sequences, randomized ops vs. model.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op, out_valid, out_ready, busy;
    logic [31:0] a, b, result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_addsub_seq #(.SAT_SHIFT(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                           input logic [31:0] vres, input int vlat, input string vname);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.res = vres; v.lat = vlat; v.name = vname;
        vq.push_back(v);
    endtask

    // Value-level model: exact integer sum of the aligned (truncated) operands, then renormalised.
    function automatic void ref_model(input logic [31:0] fa, input logic [31:0] fb, input logic fop,
                                      output logic [31:0] r, output int lat);
        logic        sa, sb, sx, sy, neg;
        logic [7:0]  ea, eb;
        logic [22:0] fra, frb;
        longint      ma, mb, mx, my, v, mag;
        logic [63:0] magb, sh;
        int          ex, ey, cnt, p, e, s;
        sa = fa[31]; sb = fb[31] ^ fop;
        ea = fa[30:23]; eb = fb[30:23];
        fra = fa[22:0]; frb = fb[22:0];
        if (ea == 8'hFF || eb == 8'hFF) begin
            lat = 1;
            if ((ea == 8'hFF && fra != 0) || (eb == 8'hFF && frb != 0) ||
                (ea == 8'hFF && eb == 8'hFF && sa != sb))
                r = 32'h7FC00000;
            else if (ea == 8'hFF)
                r = {sa, 8'hFF, 23'h0};
            else
                r = {sb, 8'hFF, 23'h0};
            return;
        end
        ma = (ea == 0) ? 64'sd0 : ((longint'(1) << 23) | longint'(fra));
        mb = (eb == 0) ? 64'sd0 : ((longint'(1) << 23) | longint'(frb));
        if (eb > ea) begin
            ex = int'(eb); ey = int'(ea); mx = mb; my = ma; sx = sb; sy = sa;
        end else begin
            ex = int'(ea); ey = int'(eb); mx = ma; my = mb; sx = sa; sy = sb;
        end
        cnt = (ex - ey > 24) ? 24 : ex - ey;
        my  = my >> cnt;
        v   = (sx ? -mx : mx) + (sy ? -my : my);
        neg = (v < 0);
        mag = neg ? -v : v;
        if (mag == 0) begin
            r = 32'h0; lat = cnt + 4;
            return;
        end
        magb = 64'(mag);
        p = 0;
        for (int i = 0; i < 26; i++) if (magb[i]) p = i;
        e = ex + p - 23;
        if (p == 24) begin
            if (e >= 255) begin
                r = {neg, 8'hFF, 23'h0}; lat = cnt + 3;
            end else begin
                sh = magb >> 1;
                r = {neg, 8'(e), sh[22:0]}; lat = cnt + 4;
            end
        end else begin
            s = 23 - p;
            if (e <= 0) begin
                r = {neg, 31'h0}; lat = cnt + 3 + ex;
            end else begin
                sh = magb << s;
                r = {neg, 8'(e), sh[22:0]}; lat = cnt + 4 + s;
            end
        end
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                         output logic [31:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a = ta; b = tbv; op = top; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 120) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    task automatic accept(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after accept"}, 32'(out_valid), 32'h0);
        check({name, " in_ready after accept"}, 32'(in_ready), 32'h1);
    endtask

    task automatic run_checked(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                               input logic [31:0] want, input int want_lat, input string name);
        logic [31:0] res;
        int          lat;
        do_op(ta, tbv, top, res, lat);
        check({name, " result"}, res, want);
        check({name, " latency"}, 32'(lat), 32'(want_lat));
        accept(name);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fa, fb, want;
        logic        fop;
        int          mode, ea, eb, want_lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
        check("reset busy", 32'(busy), 32'h0);
        check("reset result", result, 32'h0);

        add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000,  4, "one_plus_one");
        add_vec(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000,  5, "sub_one_norm");
        add_vec(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 28, "sat_shift");
        add_vec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000,  1, "inf_minus_inf");
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000,  3, "overflow");
        add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000,  4, "exact_zero");
        add_vec(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000,  1, "nan_in");
        add_vec(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000,  1, "minus_inf");
        add_vec(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000,  6, "swap_neg");
        add_vec(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 28, "denorm_flush");
        add_vec(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000,  4, "underflow");
        add_vec(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000,  1, "inf_plus_inf");
        foreach (vq[i])
            run_checked(vq[i].a, vq[i].b, vq[i].op, vq[i].res, vq[i].lat, vq[i].name);

        // Consumer stalls in DONE while the producer keeps offering pairs
        run_checked(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, "pre_stall");
        begin
            logic [31:0] res;
            int          lat;
            do_op(32'h3F800000, 32'h3F800000, 1'b0, res, lat);
            check("stall first result", res, 32'h40000000);
            for (int i = 0; i < 10; i++) begin
                in_valid = (i % 2 == 0);
                a = $urandom; b = $urandom; op = 1'b1;
                @(negedge clk);
                check("stall result", result, 32'h40000000);
                check("stall out_valid", 32'(out_valid), 32'h1);
                check("stall in_ready", 32'(in_ready), 32'h0);
            end
            in_valid = 1'b0;
            accept("stall");
        end
        run_checked(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 5, "after_stall");

        // Reset in the middle of a long alignment aborts the operation
        @(negedge clk);
        a = 32'h3F800000; b = 32'h30800000; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'h0);
        check("abort in_ready", 32'(in_ready), 32'h1);
        check("abort busy", 32'(busy), 32'h0);
        check("abort result", result, 32'h0);
        repeat (30) @(negedge clk);
        check("abort no result", 32'(out_valid), 32'h0);
        run_checked(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, "after_abort");

        for (int i = 0; i < 250; i++) begin
            mode = int'($urandom_range(0, 9));
            fa = $urandom; fb = $urandom;
            fop = 1'($urandom_range(0, 1));
            if (mode >= 1 && mode <= 6) begin
                ea = int'($urandom_range(1, 254));
                eb = ea + int'($urandom_range(0, 60)) - 30;
                if (eb < 1) eb = 1;
                if (eb > 254) eb = 254;
                fa[30:23] = 8'(ea);
                fb[30:23] = 8'(eb);
            end else if (mode == 7) begin
                fa[30:23] = 8'($urandom_range(1, 254));
                fb = fa ^ 32'($urandom_range(0, 255));
                fop = fa[31] ^ fb[31] ^ 1'b1;
            end else if (mode == 8) begin
                fa[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) fa[22:0] = '0;
                if ($urandom_range(0, 1) == 1) fb = {fb[31], 8'hFF, 23'h0};
            end else if (mode == 9) begin
                fa[30:23] = 8'($urandom_range(0, 24));
                fb[30:23] = 8'($urandom_range(0, 24));
            end
            ref_model(fa, fb, fop, want, want_lat);
            run_checked(fa, fb, fop, want, want_lat, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
